// File: rtl/cpu_types_pkg.sv
// Shared pipeline payload types and their bubble constants; each pipeline
// boundary is one pipe_stage_reg sized with $bits() of the matching struct.
package cpu_types_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OCC_W = 2;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_NONE,
        MEM_LOAD,
        MEM_STORE
    } mem_op_e;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        alu_op_e         alu_op;
        logic            alu_src_imm;
        mem_op_e         mem_op;
        logic [2:0]      mem_size;
        wb_sel_e         wb_sel;
        logic            reg_we;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        mem_op_e         mem_op;
        logic [2:0]      mem_size;
        wb_sel_e         wb_sel;
        logic            reg_we;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] load_data;
        logic [4:0]      rd;
        wb_sel_e         wb_sel;
        logic            reg_we;
    } mem_wb_t;

    // Bubbles: no register write, no memory access, so a squashed slot is inert.
    localparam id_ex_t ID_EX_RESET = '{
        pc:          '0,
        rs1_val:     '0,
        rs2_val:     '0,
        imm:         '0,
        rd:          '0,
        alu_op:      ALU_ADD,
        alu_src_imm: 1'b0,
        mem_op:      MEM_NONE,
        mem_size:    '0,
        wb_sel:      WB_NONE,
        reg_we:      1'b0
    };

    localparam ex_mem_t EX_MEM_RESET = '{
        pc:         '0,
        alu_res:    '0,
        store_data: '0,
        rd:         '0,
        mem_op:     MEM_NONE,
        mem_size:   '0,
        wb_sel:     WB_NONE,
        reg_we:     1'b0
    };

    localparam mem_wb_t MEM_WB_RESET = '{
        pc:        '0,
        alu_res:   '0,
        load_data: '0,
        rd:        '0,
        wb_sel:    WB_NONE,
        reg_we:    1'b0
    };

    function automatic logic [OCC_W-1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush. Define PIPE_STAGE_SKID_EN for a
// registered in_ready backed by one skid entry; otherwise a single entry.
module pipe_stage_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occ
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              accept;
    logic              retire;

    // Flush squashes both handshakes so nothing moves on a kill edge.
    assign accept = in_valid & in_ready & ~flush;
    assign retire = main_valid_q & out_ready & ~flush;

`ifdef PIPE_STAGE_SKID_EN

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // in_ready comes straight off a flop, breaking the out_ready -> in_ready path.
    assign in_ready = ~skid_valid_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RESET_VAL;
            skid_valid_d = 1'b0;
            skid_data_d  = RESET_VAL;
        end else if (retire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = in_data;
                end
            end else if (accept) begin
                main_data_d = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= RESET_VAL;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign occ = occ_count(main_valid_q, skid_valid_q);

`else

    assign in_ready = ~main_valid_q | out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RESET_VAL;
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end else if (retire) begin
            main_valid_d = 1'b0;
        end
    end

    assign occ = occ_count(main_valid_q, 1'b0);

`endif

    // NOTE: the data registers are reset too, because downstream may observe out_data = RESET_VAL while idle.
    always_ff @(posedge CLK) begin
        // NOTE: state uses <= so every flop samples pre-edge values regardless of statement order.
        if (RST) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RESET_VAL;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; exercises the skid variant when
// PIPE_STAGE_SKID_EN is defined, the single-entry variant otherwise.
module tb_pipe_stage_reg;

    localparam logic [31:0] RV = 32'hDEAD_0013;
`ifdef PIPE_STAGE_SKID_EN
    localparam int OCC_MAX = 2;
`else
    localparam int OCC_MAX = 1;
`endif

    logic        CLK;
    logic        RST;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occ;

    int          n_vec = 0;
    int          n_err = 0;
    logic [35:0] got;
    logic [35:0] exp;

    pipe_stage_reg #(
        .DATA_W   (32),
        .RESET_VAL(RV)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occ      (occ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [35:0] st(input logic v, input logic [1:0] o, input logic r,
                                       input logic [31:0] d);
        return {v, o, r, d};
    endfunction

    function automatic logic [35:0] dut_st();
        return {out_valid, occ, in_ready, out_data};
    endfunction

    task automatic test_reset();
        RST = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
        step();
        step();
        got = dut_st(); exp = st(1'b0, 2'd0, 1'b1, RV);
        if (got !== exp) begin
            $display("FAIL reset: got {v,occ,rdy,data}=%h want %h", got, exp); n_err++;
        end
        n_vec++;
        RST = 1'b0; in_valid = 1'b0;
        step();
        got = dut_st();
        if (got !== exp) begin
            $display("FAIL reset_idle: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 32'(k);
            #1;
            if (in_ready !== 1'b1) begin
                $display("FAIL stream_rdy[%0d]: got %b want 1", k, in_ready); n_err++;
            end
            n_vec++;
            step();
            got = dut_st(); exp = st(1'b1, 2'd1, 1'b1, 32'(k));
            if (got !== exp) begin
                $display("FAIL stream[%0d]: got %h want %h", k, got, exp); n_err++;
            end
            n_vec++;
        end
        in_valid = 1'b0;
        step();
        got = dut_st(); exp = st(1'b0, 2'd0, 1'b1, 32'd0);
        if (got[35:32] !== exp[35:32]) begin
            $display("FAIL stream_drain: got %h want %h", got[35:32], exp[35:32]); n_err++;
        end
        n_vec++;
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA; step();
        got = dut_st(); exp = st(1'b1, 2'd1, 1'b1, 32'hA);
        if (got !== exp) begin
            $display("FAIL stall_a: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
        in_data = 32'hB; step();
        got = dut_st(); exp = st(1'b1, 2'd2, 1'b0, 32'hA);
        if (got !== exp) begin
            $display("FAIL stall_b_skid: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
        in_data = 32'hC;
        for (int i = 0; i < 2; i++) begin
            step();
            got = dut_st();
            if (got !== exp) begin
                $display("FAIL stall_hold[%0d]: got %h want %h", i, got, exp); n_err++;
            end
            n_vec++;
        end
        out_ready = 1'b1; step();
        got = dut_st(); exp = st(1'b1, 2'd1, 1'b1, 32'hB);
        if (got !== exp) begin
            $display("FAIL release_b: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
        step();
        got = dut_st(); exp = st(1'b1, 2'd1, 1'b1, 32'hC);
        if (got !== exp) begin
            $display("FAIL release_c: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
        in_valid = 1'b0; step();
        got = dut_st(); exp = st(1'b0, 2'd0, 1'b1, 32'd0);
        if (got[35:32] !== exp[35:32]) begin
            $display("FAIL release_empty: got %h want %h", got[35:32], exp[35:32]); n_err++;
        end
        n_vec++;
    endtask

    task automatic fill_stage(input logic [31:0] d0, input logic [31:0] d1);
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = d0; step();
        in_data = d1; step();
    endtask
`else
    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA; step();
        got = dut_st(); exp = st(1'b1, 2'd1, 1'b0, 32'hA);
        if (got !== exp) begin
            $display("FAIL stall_a: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
        in_data = 32'hB; #1;
        if (in_ready !== 1'b0) begin
            $display("FAIL stall_rdy_same_cycle: got %b want 0", in_ready); n_err++;
        end
        n_vec++;
        for (int i = 0; i < 2; i++) begin
            step();
            got = dut_st();
            if (got !== exp) begin
                $display("FAIL stall_hold[%0d]: got %h want %h", i, got, exp); n_err++;
            end
            n_vec++;
        end
        out_ready = 1'b1; #1;
        if (in_ready !== 1'b1) begin
            $display("FAIL release_rdy: got %b want 1", in_ready); n_err++;
        end
        n_vec++;
        step();
        got = dut_st(); exp = st(1'b1, 2'd1, 1'b1, 32'hB);
        if (got !== exp) begin
            $display("FAIL release_b: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
        in_data = 32'hC; step();
        got = dut_st(); exp = st(1'b1, 2'd1, 1'b1, 32'hC);
        if (got !== exp) begin
            $display("FAIL release_c: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
        in_valid = 1'b0; step();
        got = dut_st(); exp = st(1'b0, 2'd0, 1'b1, 32'd0);
        if (got[35:32] !== exp[35:32]) begin
            $display("FAIL release_empty: got %h want %h", got[35:32], exp[35:32]); n_err++;
        end
        n_vec++;
    endtask

    task automatic fill_stage(input logic [31:0] d0, input logic [31:0] d1);
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = d0; step();
        in_data = d1; step();
    endtask
`endif

    task automatic test_flush();
        fill_stage(32'h11, 32'h12);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hD;
        step();
        got = dut_st(); exp = st(1'b0, 2'd0, 1'b1, RV);
        if (got !== exp) begin
            $display("FAIL flush: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        got = dut_st();
        if (got !== exp) begin
            $display("FAIL flush_no_d: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_reset_mid();
        fill_stage(32'h21, 32'h22);
        RST = 1'b1; in_data = 32'h99;
        step();
        got = dut_st(); exp = st(1'b0, 2'd0, 1'b1, RV);
        if (got !== exp) begin
            $display("FAIL reset_mid: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
        RST = 1'b0; in_data = 32'h5;
        step();
`ifdef PIPE_STAGE_SKID_EN
        exp = st(1'b1, 2'd1, 1'b1, 32'h5);
`else
        exp = st(1'b1, 2'd1, 1'b0, 32'h5);
`endif
        got = dut_st();
        if (got !== exp) begin
            $display("FAIL reset_first_accept: got %h want %h", got, exp); n_err++;
        end
        n_vec++;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            got = dut_st(); exp = st(1'b0, 2'd0, 1'b1, 32'd0);
            if (got[35:32] !== exp[35:32]) begin
                $display("FAIL reset_alone[%0d]: got %h want %h", i, got[35:32], exp[35:32]); n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] iv_pat;
        logic [11:0] or_pat;
        logic        acc;
        int          next_send;
        int          next_exp;
        iv_pat = 12'b1101_1011_0111;
        or_pat = 12'b1011_0010_1101;
        next_send = 100;
        next_exp  = 100;
        for (int i = 0; i < 16; i++) begin
            in_valid  = (i < 12) ? iv_pat[i] : 1'b0;
            out_ready = (i < 12) ? or_pat[i] : 1'b1;
            in_data   = 32'(next_send);
            #1;
            if (out_valid && out_ready) begin
                if (out_data !== 32'(next_exp)) begin
                    $display("FAIL b2b_order[%0d]: got %h want %h", i, out_data, 32'(next_exp)); n_err++;
                end
                n_vec++;
                next_exp++;
            end
            acc = in_valid & in_ready;
            step();
            if (acc) next_send++;
            if (int'(occ) > OCC_MAX) begin
                $display("FAIL b2b_occ[%0d]: got %0d want <= %0d", i, occ, OCC_MAX); n_err++;
            end
            n_vec++;
        end
        if (next_exp !== next_send) begin
            $display("FAIL b2b_count: retired up to %0d want %0d", next_exp, next_send); n_err++;
        end
        n_vec++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
